spike_dispatch: RTL and testbench

SPIKE_DISPATCH -- requirements
Module: spike_dispatch

---
 rtl/snn_noc_pkg.sv | 29 ++
 rtl/priority_pick.sv | 32 +++
 rtl/spike_dispatch.sv | 211 +++++++++++++++++++++
 tb/tb_spike_dispatch.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_noc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : snn_noc_pkg
//  Description : Shared definitions for the spiking-NoC dispatch logic:
//                default parameter values, dispatcher state encoding and
//                the field layout of an outbound spike packet.
//                A packet is NUM_FIELDS*ADDR_W bits wide, field f occupying
//                [f*ADDR_W +: ADDR_W]: field 1 = destination, field 0 = source.
//  Revision    : 1.0  initial release
// ============================================================================
package snn_noc_pkg;

  localparam int DEF_NUM_NEURONS = 10;
  localparam int DEF_ADDR_W      = 12;
  localparam int DEF_MAX_CONN    = 32;
  localparam int DEF_PTR_W       = 6;

  // Packet field indices (multiply by ADDR_W for the bit offset).
  localparam int PKT_SRC_FIELD   = 0;
  localparam int PKT_DST_FIELD   = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_EMIT = 2'd2
  } dispatch_state_e;

endpackage
`default_nettype wire

// File: rtl/priority_pick.sv
`default_nettype none
// ============================================================================
//  Module      : priority_pick
//  Description : Lowest-set-bit finder.
//    req   (in)  N-bit request vector
//    index (out) position of the lowest set bit of req (0 when none)
//    found (out) 1 when any bit of req is set
//  Revision    : 1.0  initial release
// ============================================================================
module priority_pick #(
  parameter int N     = 10,
  parameter int IDX_W = 4
) (
  input  logic [N-1:0]     req,
  output logic [IDX_W-1:0] index,
  output logic             found
);

  // Walk from the top down so the last hit (the lowest index) wins.
  always_comb begin
    index = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        index = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/spike_dispatch.sv
`default_nettype none
// ============================================================================
//  Module      : spike_dispatch
//  Description : At each timestep boundary, turns the local spike vector into
//                a stream of {destination, source} packets using a CSR
//                fan-out table (row pointers + destination list).
//    CLK, RESET                        clock, synchronous active-high reset
//    clear                             timestep boundary pulse
//    spikes                            per-neuron spike bits
//    *_initialization                  table images, latched while RESET=1
//    packet / packet_valid / packet_ready  outbound valid/ready stream
//    busy                              dispatch in progress
//    done                              one-cycle pulse at end of dispatch
//    overrun                           sticky: clear while busy, or a table
//                                      pointer ran past MAX_CONN
//  Revision    : 1.0  initial release
// ============================================================================
module spike_dispatch
  import snn_noc_pkg::*;
#(
  parameter int NUM_NEURONS = DEF_NUM_NEURONS,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int MAX_CONN    = DEF_MAX_CONN,
  parameter int PTR_W       = DEF_PTR_W     // 2**PTR_W must exceed MAX_CONN
) (
  input  logic                            CLK,
  input  logic                            RESET,
  input  logic                            clear,
  input  logic [NUM_NEURONS-1:0]          spikes,
  input  logic [NUM_NEURONS*ADDR_W-1:0]   neuron_addresses_initialization,
  input  logic [(NUM_NEURONS+1)*PTR_W-1:0] connection_pointer_initialization,
  input  logic [MAX_CONN*ADDR_W-1:0]      downstream_connections_initialization,
  output logic [2*ADDR_W-1:0]             packet,
  output logic                            packet_valid,
  input  logic                            packet_ready,
  output logic                            busy,
  output logic                            done,
  output logic                            overrun
);

  localparam int IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam logic [PTR_W-1:0] CONN_LIM = PTR_W'(MAX_CONN);

  // Tables
  logic [NUM_NEURONS*ADDR_W-1:0]    addr_tbl_q;
  logic [(NUM_NEURONS+1)*PTR_W-1:0] ptr_tbl_q;
  logic [MAX_CONN*ADDR_W-1:0]       dst_tbl_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      addr_tbl_q <= neuron_addresses_initialization;
      ptr_tbl_q  <= connection_pointer_initialization;
      dst_tbl_q  <= downstream_connections_initialization;
    end
  end

  // Control state
  dispatch_state_e        state_q, state_d;
  logic [NUM_NEURONS-1:0] pending_q, pending_d;
  logic [PTR_W-1:0]       cursor_q, cursor_d;
  logic [IDX_W-1:0]       cur_idx_q, cur_idx_d;
  logic [2*ADDR_W-1:0]    packet_q, packet_d;
  logic                   packet_valid_q, packet_valid_d;
  logic                   done_q, done_d;
  logic                   overrun_q, overrun_d;

  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_found;

  priority_pick #(
    .N     (NUM_NEURONS),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (pending_q),
    .index (pick_idx),
    .found (pick_found)
  );

  // The neuron being worked on: the freshly picked one in SCAN, the latched
  // one in EMIT.
  logic [IDX_W-1:0]       row_idx;
  logic [PTR_W-1:0]       row_lo, row_hi;
  logic [ADDR_W-1:0]      row_src;
  logic [NUM_NEURONS-1:0] row_mask;
  logic [PTR_W-1:0]       cursor_nxt;

  assign row_idx    = (state_q == ST_EMIT) ? cur_idx_q : pick_idx;
  assign row_mask   = NUM_NEURONS'(1) << row_idx;
  assign cursor_nxt = cursor_q + PTR_W'(1);

  // Mux-style lookup keeps every index in range for any parameter set.
  always_comb begin
    row_lo  = '0;
    row_hi  = '0;
    row_src = '0;
    for (int j = 0; j < NUM_NEURONS; j++) begin
      if (row_idx == IDX_W'(j)) begin
        row_lo  = ptr_tbl_q[j*PTR_W +: PTR_W];
        row_hi  = ptr_tbl_q[(j+1)*PTR_W +: PTR_W];
        row_src = addr_tbl_q[j*ADDR_W +: ADDR_W];
      end
    end
  end

  function automatic logic [ADDR_W-1:0] dst_at(input logic [PTR_W-1:0] k,
                                               input logic [MAX_CONN*ADDR_W-1:0] tbl);
    logic [ADDR_W-1:0] r;
    r = '0;
    for (int j = 0; j < MAX_CONN; j++) begin
      if (k == PTR_W'(j)) r = tbl[j*ADDR_W +: ADDR_W];
    end
    return r;
  endfunction

  function automatic logic [2*ADDR_W-1:0] mk_pkt(input logic [ADDR_W-1:0] dst,
                                                 input logic [ADDR_W-1:0] src);
    logic [2*ADDR_W-1:0] p;
    p = '0;
    p[PKT_DST_FIELD*ADDR_W +: ADDR_W] = dst;
    p[PKT_SRC_FIELD*ADDR_W +: ADDR_W] = src;
    return p;
  endfunction

  always_comb begin
    state_d        = state_q;
    pending_d      = pending_q;
    cursor_d       = cursor_q;
    cur_idx_d      = cur_idx_q;
    packet_d       = packet_q;
    packet_valid_d = packet_valid_q;
    done_d         = 1'b0;
    overrun_d      = overrun_q;

    // A boundary arriving mid-dispatch is dropped and flagged.
    if (clear && (state_q != ST_IDLE)) overrun_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (clear) begin
          pending_d = spikes;
          state_d   = ST_SCAN;
        end
      end

      ST_SCAN: begin
        if (!pick_found) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (row_lo == row_hi) begin
          pending_d = pending_q & ~row_mask;          // zero fan-out
        end else if (row_lo >= CONN_LIM) begin
          pending_d = pending_q & ~row_mask;          // row starts off the table
          overrun_d = 1'b1;
        end else begin
          cursor_d       = row_lo;
          cur_idx_d      = pick_idx;
          packet_d       = mk_pkt(dst_at(row_lo, dst_tbl_q), row_src);
          packet_valid_d = 1'b1;
          state_d        = ST_EMIT;
        end
      end

      ST_EMIT: begin
        if (packet_ready) begin
          if ((cursor_nxt < row_hi) && (cursor_nxt < CONN_LIM)) begin
            cursor_d = cursor_nxt;
            packet_d = mk_pkt(dst_at(cursor_nxt, dst_tbl_q), row_src);
          end else begin
            // Row ran off the end of the table: truncate and flag.
            if (cursor_nxt < row_hi) overrun_d = 1'b1;
            packet_valid_d = 1'b0;
            pending_d      = pending_q & ~row_mask;
            state_d        = ST_SCAN;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q        <= ST_IDLE;
      pending_q      <= '0;
      cursor_q       <= '0;
      cur_idx_q      <= '0;
      packet_q       <= '0;
      packet_valid_q <= 1'b0;
      done_q         <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      pending_q      <= pending_d;
      cursor_q       <= cursor_d;
      cur_idx_q      <= cur_idx_d;
      packet_q       <= packet_d;
      packet_valid_q <= packet_valid_d;
      done_q         <= done_d;
      overrun_q      <= overrun_d;
    end
  end

  assign packet       = packet_q;
  assign packet_valid = packet_valid_q;
  assign busy         = (state_q != ST_IDLE);
  assign done         = done_q;
  assign overrun      = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_spike_dispatch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spike_dispatch
//  Description : Self-checking bench for spike_dispatch. A queue-based model
//                expands spikes through the CSR tables into the expected
//                packet sequence; a negedge monitor checks every accepted
//                packet and hold stability; directed cases pin exact values.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_spike_dispatch;

  localparam int NN = 10;
  localparam int AW = 12;
  localparam int MC = 32;
  localparam int PW = 6;

  logic                   CLK = 1'b0;
  logic                   RESET = 1'b1;
  logic                   clear = 1'b0;
  logic [NN-1:0]          spikes = '0;
  logic [NN*AW-1:0]       addr_init;
  logic [(NN+1)*PW-1:0]   ptr_init;
  logic [MC*AW-1:0]       dst_init;
  logic [2*AW-1:0]        packet;
  logic                   packet_valid;
  logic                   packet_ready = 1'b1;
  logic                   busy, done, overrun;

  spike_dispatch #(
    .NUM_NEURONS (NN),
    .ADDR_W      (AW),
    .MAX_CONN    (MC),
    .PTR_W       (PW)
  ) dut (
    .CLK                                   (CLK),
    .RESET                                 (RESET),
    .clear                                 (clear),
    .spikes                                (spikes),
    .neuron_addresses_initialization       (addr_init),
    .connection_pointer_initialization     (ptr_init),
    .downstream_connections_initialization (dst_init),
    .packet                                (packet),
    .packet_valid                          (packet_valid),
    .packet_ready                          (packet_ready),
    .busy                                  (busy),
    .done                                  (done),
    .overrun                               (overrun)
  );

  always #5 CLK = ~CLK;

  // Reference tables
  int            tb_ptr  [NN+1];
  logic [AW-1:0] tb_dst  [MC];
  logic [AW-1:0] tb_addr [NN];

  always_comb begin
    for (int i = 0; i < NN; i++)  addr_init[i*AW +: AW] = tb_addr[i];
    for (int i = 0; i <= NN; i++) ptr_init[i*PW +: PW]  = PW'(tb_ptr[i]);
    for (int k = 0; k < MC; k++)  dst_init[k*AW +: AW]  = tb_dst[k];
  end

  // Model and bookkeeping
  logic [2*AW-1:0] exp_q[$];
  logic            exp_ovr = 1'b0;
  logic [2*AW-1:0] acc_log[$];
  int              acc_cyc[$];
  int              done_cnt = 0;
  int              cyc = 0;
  int              n_checks = 0;
  int              n_fail = 0;
  logic            hold_v = 1'b0;
  logic [2*AW-1:0] hold_pkt = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    n_checks++;
    n_fail++;
    $display("FAIL %s: %s", name, what);
  endtask

  // Every pending neuron, in index order, contributes its table row in order;
  // anything at or past MAX_CONN is dropped and flags overrun.
  function automatic void model_load(input logic [NN-1:0] sp);
    for (int i = 0; i < NN; i++) begin
      if (sp[i]) begin
        for (int k = tb_ptr[i]; k < tb_ptr[i+1]; k++) begin
          if (k >= MC) begin
            exp_ovr = 1'b1;
            break;
          end
          exp_q.push_back({tb_dst[k], tb_addr[i]});
        end
      end
    end
  endfunction

  function automatic void default_tables();
    int p [NN+1] = '{0, 3, 5, 8, 10, 12, 14, 15, 17, 18, 19};
    int d [8]    = '{3, 5, 7, 4, 6, 4, 5, 6};
    for (int i = 0; i <= NN; i++) tb_ptr[i] = p[i];
    for (int k = 0; k < MC; k++)  tb_dst[k] = (k < 8) ? AW'(d[k]) : AW'(12'h100 + k);
    for (int i = 0; i < NN; i++)  tb_addr[i] = AW'(i);
  endfunction

  function automatic void random_tables();
    tb_ptr[0] = $urandom_range(0, 3);
    for (int i = 0; i < NN; i++) tb_ptr[i+1] = tb_ptr[i] + $urandom_range(0, 5);
    for (int k = 0; k < MC; k++) tb_dst[k] = AW'($urandom);
    for (int i = 0; i < NN; i++) tb_addr[i] = AW'($urandom);
  endfunction

  // Monitor: one sample per cycle, half a period after the active edge.
  always @(negedge CLK) begin
    cyc++;
    if (RESET) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        chk("hold_valid", 64'(packet_valid), 64'd1);
        chk("hold_packet", 64'(packet), 64'(hold_pkt));
      end
      if (packet_valid && packet_ready) begin
        if (exp_q.size() == 0) fail_now("extra_packet", $sformatf("got %0h expected none", packet));
        else chk("packet", 64'(packet), 64'(exp_q.pop_front()));
        acc_log.push_back(packet);
        acc_cyc.push_back(cyc);
      end
      hold_v   = packet_valid && !packet_ready;
      hold_pkt = packet;
      if (done) begin
        done_cnt++;
        chk("queue_drained_at_done", 64'(exp_q.size()), 64'd0);
      end
    end
  end

  task automatic do_reset();
    RESET = 1'b1;
    clear = 1'b0;
    exp_q.delete();
    exp_ovr = 1'b0;
    repeat (2) begin @(posedge CLK); #1; end
    RESET = 1'b0;
  endtask

  // rmode: 0 always ready, 1 random ready, 2 stall 3 cycles on second packet.
  // clr_at: loop step at which a stray clear is injected (0 = never).
  task automatic run_dispatch(input logic [NN-1:0] sp, input int rmode, input int clr_at,
                              output int t_done, output int t_first);
    int d0, acc0, stall;
    model_load(sp);
    d0 = done_cnt; acc0 = acc_log.size(); stall = 0;
    t_done = -1; t_first = -1;
    spikes = sp; clear = 1'b1; packet_ready = 1'b1;
    @(posedge CLK); #1;
    clear = 1'b0;
    for (int c = 1; c <= 400; c++) begin
      case (rmode)
        1: packet_ready = 1'($urandom_range(0, 1));
        2: begin
          if ((acc_log.size() - acc0 == 1) && (stall < 3)) begin
            packet_ready = 1'b0; stall++;
          end else packet_ready = 1'b1;
        end
        default: packet_ready = 1'b1;
      endcase
      if (c == clr_at) begin
        clear = 1'b1; spikes = '1; exp_ovr = 1'b1;
      end else clear = 1'b0;
      @(posedge CLK); #1;
      if (packet_valid && t_first < 0) t_first = c;
      if (done) begin t_done = c; break; end
      chk("busy_during_dispatch", 64'(busy), 64'd1);
    end
    clear = 1'b0; packet_ready = 1'b1;
    if (t_done < 0) fail_now("dispatch_timeout", "no done within 400 cycles");
    else begin
      chk("busy_at_done", 64'(busy), 64'd0);
      chk("overrun_at_done", 64'(overrun), 64'(exp_ovr));
      @(posedge CLK); #1;
      chk("done_single_cycle", 64'(done), 64'd0);
      chk("done_count", 64'(done_cnt - d0), 64'd1);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int td, tf, a0;
    logic [NN-1:0] sp;
    int rm, ca;

    default_tables();
    do_reset();

    // Reset state
    chk("reset_valid", 64'(packet_valid), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_overrun", 64'(overrun), 64'd0);
    chk("reset_packet", 64'(packet), 64'd0);

    // Single neuron, continuous ready
    a0 = acc_log.size();
    run_dispatch(10'b0000000001, 0, 0, td, tf);
    chk("n0_count", 64'(acc_log.size() - a0), 64'd3);
    if (acc_log.size() - a0 == 3) begin
      chk("n0_pkt0", 64'(acc_log[a0]),   64'h003000);
      chk("n0_pkt1", 64'(acc_log[a0+1]), 64'h005000);
      chk("n0_pkt2", 64'(acc_log[a0+2]), 64'h007000);
      chk("n0_back_to_back", 64'(acc_cyc[a0+2] - acc_cyc[a0]), 64'd2);
    end
    chk("n0_first_latency", 64'(tf), 64'd1);
    chk("n0_done_time", 64'(td), 64'd5);

    // Two neurons, ascending order
    a0 = acc_log.size();
    run_dispatch(10'b0000000101, 0, 0, td, tf);
    chk("n02_count", 64'(acc_log.size() - a0), 64'd6);
    if (acc_log.size() - a0 == 6) begin
      chk("n02_pkt3", 64'(acc_log[a0+3]), 64'h004002);
      chk("n02_pkt5", 64'(acc_log[a0+5]), 64'h006002);
    end
    chk("n02_done_time", 64'(td), 64'd9);

    // Backpressure on the second packet
    a0 = acc_log.size();
    run_dispatch(10'b0000000001, 2, 0, td, tf);
    chk("stall_count", 64'(acc_log.size() - a0), 64'd3);
    if (acc_log.size() - a0 == 3) chk("stall_pkt1", 64'(acc_log[a0+1]), 64'h005000);
    chk("stall_done_time", 64'(td), 64'd8);

    // Stray clear mid-EMIT: original packets only, overrun set
    a0 = acc_log.size();
    run_dispatch(10'b0000000001, 0, 3, td, tf);
    chk("ovr_count", 64'(acc_log.size() - a0), 64'd3);
    chk("ovr_flag", 64'(overrun), 64'd1);
    repeat (4) begin
      @(posedge CLK); #1;
      chk("ovr_quiet_valid", 64'(packet_valid), 64'd0);
      chk("ovr_quiet_busy", 64'(busy), 64'd0);
    end

    // Reset mid-EMIT with new tables
    model_load(10'b0000000001);
    spikes = 10'b0000000001; clear = 1'b1;
    @(posedge CLK); #1; clear = 1'b0;
    repeat (2) begin @(posedge CLK); #1; end
    chk("pre_reset_valid", 64'(packet_valid), 64'd1);
    RESET = 1'b1;
    tb_dst[0] = 12'd9; tb_dst[1] = 12'd10; tb_dst[2] = 12'd11;
    exp_q.delete(); exp_ovr = 1'b0;
    @(posedge CLK); #1;
    RESET = 1'b0;
    chk("midreset_valid", 64'(packet_valid), 64'd0);
    chk("midreset_busy", 64'(busy), 64'd0);
    chk("midreset_overrun", 64'(overrun), 64'd0);
    chk("midreset_packet", 64'(packet), 64'd0);
    a0 = acc_log.size();
    run_dispatch(10'b0000000001, 0, 0, td, tf);
    if (acc_log.size() - a0 == 3) begin
      chk("reload_pkt0", 64'(acc_log[a0]),   64'h009000);
      chk("reload_pkt2", 64'(acc_log[a0+2]), 64'h00B000);
    end else fail_now("reload_count", $sformatf("got %0d expected 3", acc_log.size() - a0));

    // Zero-fanout neuron
    default_tables();
    tb_ptr[2] = 3;
    do_reset();
    a0 = acc_log.size();
    run_dispatch(10'b0000000010, 0, 0, td, tf);
    chk("zf_no_valid", 64'(tf), 64'hFFFF_FFFF_FFFF_FFFF);
    chk("zf_no_packets", 64'(acc_log.size() - a0), 64'd0);
    chk("zf_done_within_3", 64'(td <= 3), 64'd1);

    // Randomized traffic
    for (int it = 0; it < 40; it++) begin
      if (it % 8 == 0) begin
        random_tables();
        do_reset();
      end
      sp = NN'($urandom);
      rm = $urandom_range(0, 3) == 0 ? 0 : 1;
      ca = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 10) : 0;
      run_dispatch(sp, rm, ca, td, tf);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
